rs_param_station: RTL and testbench

- Parametrised reservation station, successor to the fixed 3+3-entry station.
- Sits between decode/rename and the ALU and memory units.
- Holds ALU-class and memory-class instructions in two separately sized pools, snoops NUM_CDB result buses, and issues one ready instruction per pool per cycle over valid/ready handshakes.
- ALU pool issues oldest-ready-first; memory pool issues strictly in allocation order.

---
 rtl/rs_param_station.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_rs_param_station.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_param_station.sv
// rs_param_station: reservation station with separately sized ALU and memory
// pools. Both pools snoop the result buses every cycle and each pool drives
// one registered issue port. The ALU pool issues the oldest ready entry; the
// memory pool issues only its oldest entry, once that entry is ready.

module rs_pool #(
    parameter int XLEN     = 32,
    parameter int OP_W     = 5,
    parameter int TAG_W    = 4,
    parameter int DEPTH    = 4,
    parameter int NUM_CDB  = 2,
    parameter int AUX_W    = 1,
    parameter bit IN_ORDER = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic                       alloc_i,
    input  logic [OP_W-1:0]            op_i,
    input  logic [TAG_W-1:0]           des_i,
    input  logic [XLEN-1:0]            v1_i,
    input  logic [XLEN-1:0]            v2_i,
    input  logic [TAG_W-1:0]           q1_i,
    input  logic [TAG_W-1:0]           q2_i,
    input  logic [AUX_W-1:0]           aux_i,
    input  logic [NUM_CDB-1:0]         cdb_valid_i,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag_i,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_data_i,
    input  logic                       out_ready_i,
    output logic                       out_valid_o,
    output logic [OP_W-1:0]            out_op_o,
    output logic [XLEN-1:0]            out_v1_o,
    output logic [XLEN-1:0]            out_v2_o,
    output logic [TAG_W-1:0]           out_des_o,
    output logic [AUX_W-1:0]           out_aux_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    // Entry storage; older_q[i][j] set means entry i was allocated before entry j.
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [OP_W-1:0]  op_q  [DEPTH];
    logic [OP_W-1:0]  op_d  [DEPTH];
    logic [TAG_W-1:0] des_q [DEPTH];
    logic [TAG_W-1:0] des_d [DEPTH];
    logic [XLEN-1:0]  v1_q  [DEPTH];
    logic [XLEN-1:0]  v1_d  [DEPTH];
    logic [XLEN-1:0]  v2_q  [DEPTH];
    logic [XLEN-1:0]  v2_d  [DEPTH];
    logic [TAG_W-1:0] q1_q  [DEPTH];
    logic [TAG_W-1:0] q1_d  [DEPTH];
    logic [TAG_W-1:0] q2_q  [DEPTH];
    logic [TAG_W-1:0] q2_d  [DEPTH];
    logic [AUX_W-1:0] aux_q [DEPTH];
    logic [AUX_W-1:0] aux_d [DEPTH];
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;

    // Issue register.
    logic             ov_q, ov_d;
    logic [OP_W-1:0]  oop_q, oop_d;
    logic [XLEN-1:0]  ov1_q, ov1_d, ov2_q, ov2_d;
    logic [TAG_W-1:0] odes_q, odes_d;
    logic [AUX_W-1:0] oaux_q, oaux_d;

    logic             sel_found_s, load_s, take_s;
    logic [IW-1:0]    sel_idx_s, free_idx_s;
    logic [DEPTH-1:0] rdy_s, cand_s;

    // Result-bus snoop: the lowest-numbered bus carrying a nonzero matching tag wins.
    function automatic logic [XLEN:0] cdb_lookup(
        input logic [TAG_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       vld,
        input logic [NUM_CDB*TAG_W-1:0] tags,
        input logic [NUM_CDB*XLEN-1:0]  data
    );
        logic [XLEN:0] res;
        res = {(XLEN+1){1'b0}};
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            if (vld[b] && (tag != {TAG_W{1'b0}}) && (tags[b*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, data[b*XLEN +: XLEN]};
            end
        end
        return res;
    endfunction

    // Pick the issue candidate and the lowest free slot from registered state.
    always_comb begin
        logic blk;
        blk         = 1'b0;
        sel_found_s = 1'b0;
        sel_idx_s   = {IW{1'b0}};
        free_idx_s  = {IW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            rdy_s[i] = vld_q[i] && (q1_q[i] == {TAG_W{1'b0}}) && (q2_q[i] == {TAG_W{1'b0}});
        end
        // In-order pool only looks at the oldest entry; the other looks at the oldest ready one.
        cand_s = IN_ORDER ? vld_q : rdy_s;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld_q[i]) begin
                free_idx_s = IW'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            blk = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                blk = blk | (cand_s[j] & older_q[j][i] & (i != j));
            end
            if (cand_s[i] && rdy_s[i] && !blk && !sel_found_s) begin
                sel_found_s = 1'b1;
                sel_idx_s   = IW'(i);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
        load_s = (!ov_q || out_ready_i) && !stall_i;
        take_s = load_s && sel_found_s;
    end

    // Entry next state: wakeup, free on issue, allocation with same-cycle forwarding.
    always_comb begin
        logic [XLEN:0] w1, w2, a1, a2;
        logic [DEPTH-1:0] new_bit;
        a1      = cdb_lookup(q1_i, cdb_valid_i, cdb_tag_i, cdb_data_i);
        a2      = cdb_lookup(q2_i, cdb_valid_i, cdb_tag_i, cdb_data_i);
        w1      = {(XLEN+1){1'b0}};
        w2      = {(XLEN+1){1'b0}};
        new_bit = alloc_i ? ({{(DEPTH-1){1'b0}}, 1'b1} << free_idx_s) : {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w1 = cdb_lookup(q1_q[i], cdb_valid_i, cdb_tag_i, cdb_data_i);
            w2 = cdb_lookup(q2_q[i], cdb_valid_i, cdb_tag_i, cdb_data_i);
            if (alloc_i && (free_idx_s == IW'(i))) begin
                vld_d[i]   = 1'b1;
                op_d[i]    = op_i;
                des_d[i]   = des_i;
                aux_d[i]   = aux_i;
                v1_d[i]    = a1[XLEN] ? a1[XLEN-1:0] : v1_i;
                v2_d[i]    = a2[XLEN] ? a2[XLEN-1:0] : v2_i;
                q1_d[i]    = a1[XLEN] ? {TAG_W{1'b0}} : q1_i;
                q2_d[i]    = a2[XLEN] ? {TAG_W{1'b0}} : q2_i;
                older_d[i] = {DEPTH{1'b0}};
            end else begin
                vld_d[i]   = vld_q[i] && !(take_s && (sel_idx_s == IW'(i)));
                op_d[i]    = op_q[i];
                des_d[i]   = des_q[i];
                aux_d[i]   = aux_q[i];
                v1_d[i]    = w1[XLEN] ? w1[XLEN-1:0] : v1_q[i];
                v2_d[i]    = w2[XLEN] ? w2[XLEN-1:0] : v2_q[i];
                q1_d[i]    = w1[XLEN] ? {TAG_W{1'b0}} : q1_q[i];
                q2_d[i]    = w2[XLEN] ? {TAG_W{1'b0}} : q2_q[i];
                older_d[i] = older_q[i] | new_bit;
            end
        end
        cnt_d = cnt_q + CW'(alloc_i) - CW'(take_s);
    end

    // Issue register next state: load the selected entry, drain to NOP, or hold.
    always_comb begin
        if (take_s) begin
            ov_d   = 1'b1;
            oop_d  = op_q[sel_idx_s];
            ov1_d  = v1_q[sel_idx_s];
            ov2_d  = v2_q[sel_idx_s];
            odes_d = des_q[sel_idx_s];
            oaux_d = aux_q[sel_idx_s];
        end else if (load_s) begin
            ov_d   = 1'b0;
            oop_d  = {OP_W{1'b1}};
            ov1_d  = {XLEN{1'b0}};
            ov2_d  = {XLEN{1'b0}};
            odes_d = {TAG_W{1'b0}};
            oaux_d = {AUX_W{1'b0}};
        end else begin
            ov_d   = ov_q;
            oop_d  = oop_q;
            ov1_d  = ov1_q;
            ov2_d  = ov2_q;
            odes_d = odes_q;
            oaux_d = oaux_q;
        end
    end

    // Control state update; reset and flush both empty the pool.
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            vld_q  <= {DEPTH{1'b0}};
            cnt_q  <= {CW{1'b0}};
            ov_q   <= 1'b0;
            oop_q  <= {OP_W{1'b1}};
            ov1_q  <= {XLEN{1'b0}};
            ov2_q  <= {XLEN{1'b0}};
            odes_q <= {TAG_W{1'b0}};
            oaux_q <= {AUX_W{1'b0}};
        end else begin
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
            ov_q   <= ov_d;
            oop_q  <= oop_d;
            ov1_q  <= ov1_d;
            ov2_q  <= ov2_d;
            odes_q <= odes_d;
            oaux_q <= oaux_d;
        end
    end

    // Entry payload update; contents are meaningless while the valid bit is clear.
    always_ff @(posedge clk_i) begin
        op_q    <= op_d;
        des_q   <= des_d;
        v1_q    <= v1_d;
        v2_q    <= v2_d;
        q1_q    <= q1_d;
        q2_q    <= q2_d;
        aux_q   <= aux_d;
        older_q <= older_d;
    end

    assign out_valid_o = ov_q;
    assign out_op_o    = oop_q;
    assign out_v1_o    = ov1_q;
    assign out_v2_o    = ov2_q;
    assign out_des_o   = odes_q;
    assign out_aux_o   = oaux_q;
    assign count_o     = cnt_q;
    assign full_o      = (cnt_q == CW'(DEPTH));
endmodule

module rs_param_station #(
    parameter int XLEN      = 32,
    parameter int OP_W      = 5,
    parameter int TAG_W     = 4,
    parameter int ALU_DEPTH = 4,
    parameter int MEM_DEPTH = 4,
    parameter int NUM_CDB   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [OP_W-1:0]                in_op,
    input  logic [TAG_W-1:0]               in_des,
    input  logic [XLEN-1:0]                in_v1,
    input  logic [XLEN-1:0]                in_v2,
    input  logic [TAG_W-1:0]               in_q1,
    input  logic [TAG_W-1:0]               in_q2,
    input  logic [XLEN-1:0]                in_imm,
    input  logic                           in_br,
    input  logic [NUM_CDB-1:0]             cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]       cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]        cdb_data,
    output logic                           alu_valid,
    input  logic                           alu_ready,
    output logic [OP_W-1:0]                alu_op,
    output logic [XLEN-1:0]                alu_v1,
    output logic [XLEN-1:0]                alu_v2,
    output logic [TAG_W-1:0]               alu_des,
    output logic                           alu_br,
    output logic                           mem_valid,
    input  logic                           mem_ready,
    output logic [OP_W-1:0]                mem_op,
    output logic [XLEN-1:0]                mem_v1,
    output logic [XLEN-1:0]                mem_v2,
    output logic [XLEN-1:0]                mem_imm,
    output logic [TAG_W-1:0]               mem_des,
    output logic [$clog2(ALU_DEPTH+1)-1:0] alu_count,
    output logic [$clog2(MEM_DEPTH+1)-1:0] mem_count
);
    // LB..SW opcode window selects the memory pool.
    localparam logic [OP_W-1:0] OP_LB = OP_W'(5'h12);
    localparam logic [OP_W-1:0] OP_SW = OP_W'(5'h19);

    logic is_mem_s, alu_full_s, mem_full_s, alu_alloc_s, mem_alloc_s;

    // Classify the dispatched opcode and grant it if its pool has room.
    always_comb begin
        is_mem_s = (in_op >= OP_LB) && (in_op <= OP_SW);
        if (stall || flush) begin
            in_ready = 1'b0;
        end else if (is_mem_s) begin
            in_ready = !mem_full_s;
        end else begin
            in_ready = !alu_full_s;
        end
        alu_alloc_s = in_valid && in_ready && !is_mem_s;
        mem_alloc_s = in_valid && in_ready && is_mem_s;
    end

    rs_pool #(
        .XLEN(XLEN), .OP_W(OP_W), .TAG_W(TAG_W), .DEPTH(ALU_DEPTH),
        .NUM_CDB(NUM_CDB), .AUX_W(1), .IN_ORDER(1'b0)
    ) u_alu_pool (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .alloc_i(alu_alloc_s), .op_i(in_op), .des_i(in_des),
        .v1_i(in_v1), .v2_i(in_v2), .q1_i(in_q1), .q2_i(in_q2), .aux_i(in_br),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
        .out_ready_i(alu_ready), .out_valid_o(alu_valid), .out_op_o(alu_op),
        .out_v1_o(alu_v1), .out_v2_o(alu_v2), .out_des_o(alu_des), .out_aux_o(alu_br),
        .count_o(alu_count), .full_o(alu_full_s)
    );

    rs_pool #(
        .XLEN(XLEN), .OP_W(OP_W), .TAG_W(TAG_W), .DEPTH(MEM_DEPTH),
        .NUM_CDB(NUM_CDB), .AUX_W(XLEN), .IN_ORDER(1'b1)
    ) u_mem_pool (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .alloc_i(mem_alloc_s), .op_i(in_op), .des_i(in_des),
        .v1_i(in_v1), .v2_i(in_v2), .q1_i(in_q1), .q2_i(in_q2), .aux_i(in_imm),
        .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag), .cdb_data_i(cdb_data),
        .out_ready_i(mem_ready), .out_valid_o(mem_valid), .out_op_o(mem_op),
        .out_v1_o(mem_v1), .out_v2_o(mem_v2), .out_des_o(mem_des), .out_aux_o(mem_imm),
        .count_o(mem_count), .full_o(mem_full_s)
    );
endmodule

// File: tb/tb_rs_param_station.sv
// Bench for rs_param_station: a queue-based model of both pools runs alongside
// the DUT; accepted issues are predicted into scoreboards and a monitor pops
// and compares them whenever the DUT hands an instruction over.

module tb_rs_param_station;
    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, in_ready, in_br;
    logic [4:0]  in_op;
    logic [3:0]  in_des, in_q1, in_q2;
    logic [31:0] in_v1, in_v2, in_imm;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_data;
    logic        alu_valid, alu_ready, alu_br, mem_valid, mem_ready;
    logic [4:0]  alu_op, mem_op;
    logic [31:0] alu_v1, alu_v2, mem_v1, mem_v2, mem_imm;
    logic [3:0]  alu_des, mem_des;
    logic [2:0]  alu_count, mem_count;

    rs_param_station dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_des(in_des),
        .in_v1(in_v1), .in_v2(in_v2), .in_q1(in_q1), .in_q2(in_q2),
        .in_imm(in_imm), .in_br(in_br),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_des(alu_des), .alu_br(alu_br),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_op(mem_op),
        .mem_v1(mem_v1), .mem_v2(mem_v2), .mem_imm(mem_imm), .mem_des(mem_des),
        .alu_count(alu_count), .mem_count(mem_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [3:0]  des;
        logic [31:0] v1, v2;
        logic [3:0]  q1, q2;
        logic [31:0] aux;
    } ent_t;

    ent_t alu_q[$], mem_q[$], exp_alu[$], exp_mem[$];
    ent_t m_ai, m_mi, nop_e;
    bit   m_av, m_mv, m_sync;
    bit   s_av, s_mv, s_sync, s_ir;
    int   s_ac, s_mc;
    int   n_chk = 0, n_fail = 0, n_acc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_mem(input logic [4:0] op);
        return (op >= 5'h12) && (op <= 5'h19);
    endfunction

    // First bus (lowest index) carrying the tag supplies the value.
    function automatic bit lookup(input logic [3:0] q, output logic [31:0] d);
        bit hit;
        hit = 1'b0;
        d = 32'h0;
        if (q != 4'h0) begin
            for (int b = 0; b < 2; b++) begin
                if (!hit && cdb_valid[b] && cdb_tag[b*4 +: 4] == q) begin
                    hit = 1'b1;
                    d = cdb_data[b*32 +: 32];
                end
            end
        end
        return hit;
    endfunction

    function automatic ent_t wake(input ent_t e);
        ent_t r;
        logic [31:0] d;
        r = e;
        if (lookup(e.q1, d)) begin r.v1 = d; r.q1 = 4'h0; end
        if (lookup(e.q2, d)) begin r.v2 = d; r.q2 = 4'h0; end
        return r;
    endfunction

    function automatic bit rdy(input ent_t e);
        return (e.q1 == 4'h0) && (e.q2 == 4'h0);
    endfunction

    // Reference model: pools are age-ordered queues, evaluated once per cycle.
    always @(negedge clk) begin
        int ai;
        bit mr;
        ent_t e;
        logic [31:0] d;
        s_sync = m_sync;
        s_av = m_av;
        s_mv = m_mv;
        s_ac = alu_q.size();
        s_mc = mem_q.size();
        s_ir = !stall && !flush && (is_mem(in_op) ? (mem_q.size() < 4) : (alu_q.size() < 4));
        if (!rst || flush) begin
            alu_q.delete();
            mem_q.delete();
            m_av = 1'b0; m_mv = 1'b0; m_ai = nop_e; m_mi = nop_e;
            if (!rst) m_sync = 1'b1;
        end else begin
            if (m_av && alu_ready && !stall) exp_alu.push_back(m_ai);
            if (m_mv && mem_ready && !stall) exp_mem.push_back(m_mi);
            ai = -1;
            foreach (alu_q[k]) if (ai < 0 && rdy(alu_q[k])) ai = k;
            mr = (mem_q.size() > 0) && rdy(mem_q[0]);
            foreach (alu_q[k]) alu_q[k] = wake(alu_q[k]);
            foreach (mem_q[k]) mem_q[k] = wake(mem_q[k]);
            if ((!m_av || alu_ready) && !stall) begin
                if (ai >= 0) begin m_ai = alu_q[ai]; alu_q.delete(ai); m_av = 1'b1; end
                else begin m_ai = nop_e; m_av = 1'b0; end
            end
            if ((!m_mv || mem_ready) && !stall) begin
                if (mr) begin m_mi = mem_q.pop_front(); m_mv = 1'b1; end
                else begin m_mi = nop_e; m_mv = 1'b0; end
            end
            if (in_valid && s_ir) begin
                e.op = in_op; e.des = in_des; e.v1 = in_v1; e.v2 = in_v2;
                e.q1 = in_q1; e.q2 = in_q2;
                if (in_q1 != 4'h0 && lookup(in_q1, d)) begin e.v1 = d; e.q1 = 4'h0; end
                if (in_q2 != 4'h0 && lookup(in_q2, d)) begin e.v2 = d; e.q2 = 4'h0; end
                if (is_mem(in_op)) begin e.aux = in_imm; mem_q.push_back(e); end
                else begin e.aux = {31'h0, in_br}; alu_q.push_back(e); end
            end
        end
    end

    // Monitor: per-cycle status checks plus scoreboard pops on accepted issues.
    always @(negedge clk) begin
        ent_t e;
        #1;
        if (s_sync) begin
            chk("alu_valid", {31'h0, alu_valid}, {31'h0, s_av});
            chk("mem_valid", {31'h0, mem_valid}, {31'h0, s_mv});
            if (!s_av) chk("alu_op_nop", {27'h0, alu_op}, 32'h1F);
            if (!s_mv) chk("mem_op_nop", {27'h0, mem_op}, 32'h1F);
            chk("alu_count", {29'h0, alu_count}, s_ac);
            chk("mem_count", {29'h0, mem_count}, s_mc);
            chk("in_ready", {31'h0, in_ready}, {31'h0, s_ir});
            if (rst && !flush && !stall && alu_valid && alu_ready) begin
                if (exp_alu.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL alu_unexpected: got op %0h expected no issue", alu_op);
                end else begin
                    e = exp_alu.pop_front();
                    n_acc++;
                    chk("alu_op", {27'h0, alu_op}, {27'h0, e.op});
                    chk("alu_v1", alu_v1, e.v1);
                    chk("alu_v2", alu_v2, e.v2);
                    chk("alu_des", {28'h0, alu_des}, {28'h0, e.des});
                    chk("alu_br", {31'h0, alu_br}, {31'h0, e.aux[0]});
                end
            end
            if (rst && !flush && !stall && mem_valid && mem_ready) begin
                if (exp_mem.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL mem_unexpected: got op %0h expected no issue", mem_op);
                end else begin
                    e = exp_mem.pop_front();
                    n_acc++;
                    chk("mem_op", {27'h0, mem_op}, {27'h0, e.op});
                    chk("mem_v1", mem_v1, e.v1);
                    chk("mem_v2", mem_v2, e.v2);
                    chk("mem_imm", mem_imm, e.aux);
                    chk("mem_des", {28'h0, mem_des}, {28'h0, e.des});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_op = 5'h1F; in_des = 4'h0; in_v1 = 32'h0; in_v2 = 32'h0;
        in_q1 = 4'h0; in_q2 = 4'h0; in_imm = 32'h0; in_br = 1'b0;
        cdb_valid = 2'b00; cdb_tag = 8'h0; cdb_data = 64'h0;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic disp(input logic [4:0] op, input logic [3:0] des, input logic [3:0] q1,
                        input logic [31:0] v1, input logic [3:0] q2, input logic [31:0] v2,
                        input logic [31:0] imm);
        in_valid = 1'b1; in_op = op; in_des = des; in_q1 = q1; in_v1 = v1;
        in_q2 = q2; in_v2 = v2; in_imm = imm; in_br = des[0];
    endtask

    task automatic cdb(input int b, input logic [3:0] tag, input logic [31:0] data);
        cdb_valid[b] = 1'b1;
        cdb_tag[b*4 +: 4] = tag;
        cdb_data[b*32 +: 32] = data;
    endtask

    task automatic rand_cycle(input int rdy_pct);
        idle();
        rst = ($urandom_range(0, 499) != 0);
        in_valid = ($urandom_range(0, 9) < 6);
        in_op = 5'($urandom_range(0, 31));
        in_des = 4'($urandom_range(1, 15));
        in_q1 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        in_q2 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        in_v1 = $urandom; in_v2 = $urandom; in_imm = $urandom;
        in_br = 1'($urandom_range(0, 1));
        for (int b = 0; b < 2; b++) begin
            if ($urandom_range(0, 9) < 4) cdb(b, 4'($urandom_range(0, 15)), $urandom);
        end
        alu_ready = ($urandom_range(0, 99) < rdy_pct);
        mem_ready = ($urandom_range(0, 99) < rdy_pct);
        stall = ($urandom_range(0, 9) == 0);
        flush = ($urandom_range(0, 59) == 0);
    endtask

    initial begin
        nop_e = '{op: 5'h1F, des: 4'h0, v1: 32'h0, v2: 32'h0, q1: 4'h0, q2: 4'h0, aux: 32'h0};
        m_ai = nop_e; m_mi = nop_e; m_av = 1'b0; m_mv = 1'b0; m_sync = 1'b0;
        idle(); alu_ready = 1'b1; mem_ready = 1'b1;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        // Operand 2 arrives on bus 0 two cycles after dispatch.
        disp(5'h00, 4'h1, 4'h0, 32'd5, 4'h3, 32'h0, 32'h0); tick(); idle();
        repeat (2) tick();
        cdb(0, 4'h3, 32'd7); tick(); idle();
        repeat (4) tick();
        // Fill the ALU pool behind a stalled unit; oldest waits on tag 2.
        alu_ready = 1'b0;
        disp(5'h02, 4'h2, 4'h2, 32'h0, 4'h0, 32'd11, 32'h0); tick();
        for (int k = 0; k < 5; k++) begin
            disp(5'(k + 3), 4'(k + 3), 4'h0, 32'(k), 4'h0, 32'(k * 2), 32'h0); tick();
        end
        disp(5'h12, 4'h9, 4'h0, 32'h10, 4'h0, 32'h0, 32'h20); tick(); idle();
        alu_ready = 1'b1;
        repeat (3) tick();
        cdb(1, 4'h2, 32'h22); tick(); idle();
        repeat (6) tick();
        // Load waits on tag 4; the ready store behind it must not pass.
        disp(5'h12, 4'h6, 4'h4, 32'h0, 4'h0, 32'h0, 32'h100); tick();
        disp(5'h19, 4'h7, 4'h0, 32'h55, 4'h0, 32'h66, 32'h104); tick(); idle();
        repeat (3) tick();
        cdb(1, 4'h4, 32'h40); tick(); idle();
        repeat (4) tick();
        // Operand forwarded from the bus in the dispatch cycle.
        disp(5'h01, 4'h8, 4'h6, 32'h0, 4'h0, 32'h9, 32'h0); cdb(0, 4'h6, 32'hDEAD); tick(); idle();
        repeat (4) tick();
        // Flush with both pools occupied and an un-accepted ALU issue.
        alu_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            disp(5'(k), 4'(k + 1), 4'h0, 32'(k), 4'h0, 32'h0, 32'h0); tick();
        end
        disp(5'h13, 4'h5, 4'h9, 32'h0, 4'h0, 32'h0, 32'h8); tick();
        disp(5'h14, 4'h6, 4'h0, 32'h1, 4'h0, 32'h0, 32'hC); tick(); idle();
        tick();
        flush = 1'b1; cdb(0, 4'h9, 32'h1); tick(); idle();
        alu_ready = 1'b1;
        repeat (3) tick();
        // Random traffic, first with a sluggish consumer so pools fill, then a fast one.
        for (int k = 0; k < 3000; k++) begin
            rand_cycle((k < 1500) ? 35 : 85);
            tick();
        end
        // Drain: broadcast every tag so all waiting entries complete.
        idle(); rst = 1'b1; alu_ready = 1'b1; mem_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            cdb(0, 4'((k % 15) + 1), 32'(k));
            cdb(1, 4'(((k + 7) % 15) + 1), 32'(k + 100));
            tick();
        end
        idle();
        repeat (8) tick();
        chk("alu_sb_drained", exp_alu.size(), 32'd0);
        chk("mem_sb_drained", exp_mem.size(), 32'd0);
        chk("alu_pool_empty", {29'h0, alu_count}, 32'd0);
        chk("mem_pool_empty", {29'h0, mem_count}, 32'd0);
        chk("issues_seen", (n_acc > 200) ? 32'd1 : 32'd0, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
